xbar_pipe: RTL

//  Parametrised, pipelined N-port router crossbar for the BLESS-age router datapath; successor to the fixed
//  5-port/13b-ctrl/8b-data crossbar. Each output selects one input per cycle from route_config.

---
 rtl/xbar_pkg.sv | 22 ++
 rtl/xbar_out_mux.sv | 91 +++++++++
 rtl/xbar_pipe.sv | 108 ++++++++++
 3 files changed

// File: rtl/xbar_pkg.sv
// Shared crossbar definitions: default geometry, idle-select encoding, error flag bundle.
package xbar_pkg;

  localparam int XB_NPORTS_DEF = 5;
  localparam int XB_CTRL_W_DEF = 13;
  localparam int XB_DATA_W_DEF = 8;
  localparam int XB_SEL_W_DEF  = 3;
  localparam int XB_PIPE_DEF   = 1;
  localparam int XB_CNT_W_DEF  = 16;

  typedef struct packed {
    logic dup;
    logic drop;
    logic cfg;
  } xbar_err_t;

  // All-ones select code marks an output as idle.
  function automatic int sel_none(input int sel_w);
    return (1 << sel_w) - 1;
  endfunction

endpackage

// File: rtl/xbar_out_mux.sv
// One crossbar output: select decode with zero-fill, PIPE_STAGES-deep register chain, saturating flit counter.
// Latency PIPE_STAGES cycles; no backpressure, accepts a flit every cycle.
module xbar_out_mux
  import xbar_pkg::*;
#(
  parameter int NPORTS      = XB_NPORTS_DEF,
  parameter int CTRL_W      = XB_CTRL_W_DEF,
  parameter int DATA_W      = XB_DATA_W_DEF,
  parameter int SEL_W       = XB_SEL_W_DEF,
  parameter int PIPE_STAGES = XB_PIPE_DEF,
  parameter int CNT_W       = XB_CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*CTRL_W-1:0] ctrl_in,
  input  logic [NPORTS*DATA_W-1:0] data_in,
  input  logic [SEL_W-1:0]         sel,
  input  logic                     stat_clr,
  output logic                     out_valid,
  output logic [CTRL_W-1:0]        ctrl_out,
  output logic [DATA_W-1:0]        data_out,
  output logic [CNT_W-1:0]         cnt
);

  logic                                hit_d;
  logic [CTRL_W-1:0]                   ctrl_d;
  logic [DATA_W-1:0]                   data_d;
  logic [PIPE_STAGES-1:0]              vld_q;
  logic [PIPE_STAGES-1:0][CTRL_W-1:0]  ctrl_q;
  logic [PIPE_STAGES-1:0][DATA_W-1:0]  data_q;
  logic [PIPE_STAGES:0]                vld_chain;
  logic [CNT_W-1:0]                    cnt_d, cnt_q;

  // Out-of-range selects never match an input, so they fall through to idle zeros.
  always_comb begin
    hit_d  = 1'b0;
    ctrl_d = '0;
    data_d = '0;
    for (int i = 0; i < NPORTS; i++) begin
      if (int'(sel) == i && in_valid[i]) begin
        hit_d  = 1'b1;
        ctrl_d = ctrl_in[i*CTRL_W +: CTRL_W];
        data_d = data_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld_q  <= '0;
      ctrl_q <= '0;
      data_q <= '0;
    end else begin
      vld_q[0]  <= hit_d;
      ctrl_q[0] <= ctrl_d;
      data_q[0] <= data_d;
      for (int s = 1; s < PIPE_STAGES; s++) begin
        vld_q[s]  <= vld_q[s-1];
        ctrl_q[s] <= ctrl_q[s-1];
        data_q[s] <= data_q[s-1];
      end
    end
  end

  // Bit PIPE_STAGES-1 is the value being loaded into the final stage this cycle.
  assign vld_chain = {vld_q, hit_d};
  assign out_valid = vld_chain[PIPE_STAGES];
  assign ctrl_out  = ctrl_q[PIPE_STAGES-1];
  assign data_out  = data_q[PIPE_STAGES-1];

  always_comb begin
    cnt_d = cnt_q;
    if (stat_clr) begin
      cnt_d = '0;
    end else if (vld_chain[PIPE_STAGES-1] && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/xbar_pipe.sv
// Pipelined N-port crossbar: per-output muxes, dup/drop/cfg error flags aligned with the data, counter readout.
// Latency PIPE_STAGES cycles for data and flags; no backpressure, 1 flit/port/cycle.
module xbar_pipe
  import xbar_pkg::*;
#(
  parameter int NPORTS      = XB_NPORTS_DEF,
  parameter int CTRL_W      = XB_CTRL_W_DEF,
  parameter int DATA_W      = XB_DATA_W_DEF,
  parameter int SEL_W       = XB_SEL_W_DEF,
  parameter int PIPE_STAGES = XB_PIPE_DEF,
  parameter int CNT_W       = XB_CNT_W_DEF
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [NPORTS-1:0]        in_valid,
  input  logic [NPORTS*CTRL_W-1:0] ctrl_in,
  input  logic [NPORTS*DATA_W-1:0] data_in,
  input  logic [NPORTS*SEL_W-1:0]  route_config,
  input  logic [SEL_W-1:0]         stat_sel,
  input  logic                     stat_clr,
  output logic [NPORTS-1:0]        out_valid,
  output logic [NPORTS*CTRL_W-1:0] ctrl_out,
  output logic [NPORTS*DATA_W-1:0] data_out,
  output logic                     dup_err,
  output logic                     drop_err,
  output logic                     cfg_err,
  output logic [CNT_W-1:0]         stat_cnt
);

  localparam int SEL_NONE = sel_none(SEL_W);

  logic [NPORTS*CNT_W-1:0]      cnt_all;
  logic [NPORTS-1:0]            used, multi;
  logic [SEL_W-1:0]             s;
  xbar_err_t                    err_d;
  xbar_err_t [PIPE_STAGES-1:0]  err_q;

  for (genvar o = 0; o < NPORTS; o++) begin : g_out
    xbar_out_mux #(
      .NPORTS      (NPORTS),
      .CTRL_W      (CTRL_W),
      .DATA_W      (DATA_W),
      .SEL_W       (SEL_W),
      .PIPE_STAGES (PIPE_STAGES),
      .CNT_W       (CNT_W)
    ) u_mux (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .ctrl_in   (ctrl_in),
      .data_in   (data_in),
      .sel       (route_config[o*SEL_W +: SEL_W]),
      .stat_clr  (stat_clr),
      .out_valid (out_valid[o]),
      .ctrl_out  (ctrl_out[o*CTRL_W +: CTRL_W]),
      .data_out  (data_out[o*DATA_W +: DATA_W]),
      .cnt       (cnt_all[o*CNT_W +: CNT_W])
    );
  end

  // Count how many outputs claim each input; only valid inputs can raise dup/drop.
  always_comb begin
    used  = '0;
    multi = '0;
    s     = '0;
    err_d = '0;
    for (int o = 0; o < NPORTS; o++) begin
      s = route_config[o*SEL_W +: SEL_W];
      if (int'(s) < NPORTS) begin
        for (int i = 0; i < NPORTS; i++) begin
          if (int'(s) == i) begin
            multi[i] = multi[i] | used[i];
            used[i]  = 1'b1;
          end
        end
      end else if (int'(s) != SEL_NONE) begin
        err_d.cfg = 1'b1;
      end
    end
    err_d.dup  = |(multi & in_valid);
    err_d.drop = |(~used & in_valid);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= '0;
    end else begin
      err_q[0] <= err_d;
      for (int st = 1; st < PIPE_STAGES; st++) begin
        err_q[st] <= err_q[st-1];
      end
    end
  end

  assign dup_err  = err_q[PIPE_STAGES-1].dup;
  assign drop_err = err_q[PIPE_STAGES-1].drop;
  assign cfg_err  = err_q[PIPE_STAGES-1].cfg;

  always_comb begin
    stat_cnt = '0;
    for (int o = 0; o < NPORTS; o++) begin
      if (int'(stat_sel) == o) begin
        stat_cnt = cnt_all[o*CNT_W +: CNT_W];
      end
    end
  end

endmodule
